// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver (configurable data bits, parity, stop bits)
// with input synchroniser, parity/framing error flags and a valid/ready holding register.
module uart_rx_frame #(
   parameter int unsigned CLKS_PER_BIT = 279,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   input  logic                 ready,
   output logic [DATA_BITS-1:0] data_rx,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned HALF = CLKS_PER_BIT / 2;
   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW   = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF      = CW'(HALF - 1);
   localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [IW-1:0]        idx, idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 perr_f, perr_f_nxt;
   logic                 ferr_f, ferr_f_nxt;
   logic                 armed, armed_nxt;
   logic                 din_m, din_s;

   logic [DATA_BITS-1:0] data_rx_nxt;
   logic                 valid_nxt, parity_err_nxt, frame_err_nxt, overrun_nxt, busy_nxt;
   logic                 done_c;
   logic                 fin_ferr_c;

   // Two-flop synchroniser for the asynchronous RX line (idles high).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         din_m <= 1'b1;
         din_s <= 1'b1;
      end else begin
         din_m <= din;
         din_s <= din_m;
      end
   end

   // Next-state, datapath and output-register update.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      idx_nxt        = idx;
      shreg_nxt      = shreg;
      perr_f_nxt     = perr_f;
      ferr_f_nxt     = ferr_f;
      armed_nxt      = armed | din_s;
      done_c         = 1'b0;
      fin_ferr_c     = ferr_f;
      data_rx_nxt    = data_rx;
      valid_nxt      = valid;
      parity_err_nxt = parity_err;
      frame_err_nxt  = frame_err;
      overrun_nxt    = 1'b0;

      unique case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            idx_nxt = '0;
            // A start needs a high line seen since the last start, so a break cannot retrigger.
            if (!din_s && armed) begin
               state_nxt  = S_START;
               armed_nxt  = 1'b0;
               perr_f_nxt = 1'b0;
               ferr_f_nxt = 1'b0;
            end
         end
         S_START: begin
            if (cnt == CNT_HALF) begin
               cnt_nxt   = '0;
               state_nxt = din_s ? S_IDLE : S_DATA;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               shreg_nxt = {din_s, shreg[DATA_BITS-1:1]};
               if (idx == IDX_DATA_LAST) begin
                  idx_nxt   = '0;
                  state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  idx_nxt = idx + IW'(1);
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_PARITY: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt    = '0;
               perr_f_nxt = (PARITY == 2) ? ~(^shreg ^ din_s) : (^shreg ^ din_s);
               state_nxt  = S_STOP;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (!din_s) begin
                  ferr_f_nxt = 1'b1;
               end
               if (idx == IDX_STOP_LAST) begin
                  idx_nxt    = '0;
                  state_nxt  = S_IDLE;
                  done_c     = 1'b1;
                  fin_ferr_c = ferr_f | ~din_s;
               end else begin
                  idx_nxt = idx + IW'(1);
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase

      // Holding register: a completing frame wins over a simultaneous handshake.
      if (done_c) begin
         if (!valid || ready) begin
            data_rx_nxt    = shreg_nxt;
            parity_err_nxt = perr_f_nxt;
            frame_err_nxt  = fin_ferr_c;
            valid_nxt      = 1'b1;
         end else begin
            overrun_nxt = 1'b1;
         end
      end else if (valid && ready) begin
         valid_nxt      = 1'b0;
         parity_err_nxt = 1'b0;
         frame_err_nxt  = 1'b0;
      end

      busy_nxt = (state_nxt != S_IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         perr_f     <= 1'b0;
         ferr_f     <= 1'b0;
         armed      <= 1'b1;
         data_rx    <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         shreg      <= shreg_nxt;
         perr_f     <= perr_f_nxt;
         ferr_f     <= ferr_f_nxt;
         armed      <= armed_nxt;
         data_rx    <= data_rx_nxt;
         valid      <= valid_nxt;
         parity_err <= parity_err_nxt;
         frame_err  <= frame_err_nxt;
         overrun    <= overrun_nxt;
         busy       <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance (a) and an 8E2 instance (b), 16 clocks/bit.
module tb_uart_rx_frame;

   localparam int unsigned CPB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       din_a, ready_a, din_b, ready_b;
   logic [7:0] data_rx_a, data_rx_b;
   logic       valid_a, parity_err_a, frame_err_a, overrun_a, busy_a;
   logic       valid_b, parity_err_b, frame_err_b, overrun_b, busy_b;

   int n_cmp = 0;
   int n_err = 0;
   int ov_a  = 0;
   int ov_b  = 0;
   int ov0;

   logic [9:0] qa[$];
   logic [9:0] qb[$];

   always #5 clk = ~clk;

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst), .din(din_a), .ready(ready_a),
      .data_rx(data_rx_a), .valid(valid_a), .parity_err(parity_err_a),
      .frame_err(frame_err_a), .overrun(overrun_a), .busy(busy_a)
   );

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_b (
      .clk(clk), .rst(rst), .din(din_b), .ready(ready_b),
      .data_rx(data_rx_b), .valid(valid_b), .parity_err(parity_err_b),
      .frame_err(frame_err_b), .overrun(overrun_b), .busy(busy_b)
   );

   // Record every handshaken word and count overrun cycles, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         if (valid_a && ready_a) qa.push_back({parity_err_a, frame_err_a, data_rx_a});
         if (valid_b && ready_b) qb.push_back({parity_err_b, frame_err_b, data_rx_b});
         if (overrun_a) ov_a++;
         if (overrun_b) ov_b++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive n line bits LSB first, one bit time each.
   task automatic send_line(input int sel, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel == 0) din_a = bits[i];
         else          din_b = bits[i];
         repeat (CPB) tick();
      end
   endtask

   function automatic logic [15:0] frame_a(input logic [7:0] d);
      return {6'b0, 1'b1, d, 1'b0};
   endfunction

   function automatic logic [15:0] frame_b(input logic [7:0] d, input logic par, input logic s2);
      return {4'b0, s2, 1'b1, par, d, 1'b0};
   endfunction

   task automatic expect_word(input int sel, input string tag, input logic [7:0] d,
                              input logic pe, input logic fe);
      logic [9:0] w;
      int         sz;
      sz = (sel == 0) ? qa.size() : qb.size();
      chk({tag, "_present"}, 32'(sz > 0), 32'd1);
      if (sz > 0) begin
         if (sel == 0) w = qa.pop_front();
         else          w = qb.pop_front();
         chk({tag, "_data"}, 32'(w[7:0]), 32'(d));
         chk({tag, "_perr"}, 32'(w[9]), 32'(pe));
         chk({tag, "_ferr"}, 32'(w[8]), 32'(fe));
      end
   endtask

   initial begin
      rst = 1'b0; din_a = 1'b1; din_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
      repeat (3) tick();
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_data", 32'(data_rx_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_flags", 32'({parity_err_a, frame_err_a, overrun_a}), 32'd0);
      chk("rst_valid_b", 32'(valid_b), 32'd0);
      rst = 1'b1;
      repeat (4) tick();

      // Back-to-back 8N1 frames with ready high.
      ov0 = ov_a;
      send_line(0, frame_a(8'hA5), 10);
      send_line(0, frame_a(8'h3C), 10);
      din_a = 1'b1;
      repeat (40) tick();
      expect_word(0, "b2b_w0", 8'hA5, 1'b0, 1'b0);
      expect_word(0, "b2b_w1", 8'h3C, 1'b0, 1'b0);
      chk("b2b_extra", 32'(qa.size()), 32'd0);
      chk("b2b_overrun", 32'(ov_a - ov0), 32'd0);

      // Short low glitch must be rejected at the half-bit check.
      din_a = 1'b0;
      repeat (5) tick();
      chk("glitch_busy_mid", 32'(busy_a), 32'd1);
      din_a = 1'b1;
      repeat (20) tick();
      chk("glitch_busy_after", 32'(busy_a), 32'd0);
      chk("glitch_nowords", 32'(qa.size()), 32'd0);

      // Consumer stalled: second frame overruns and is dropped.
      ready_a = 1'b0;
      ov0 = ov_a;
      send_line(0, frame_a(8'h11), 10);
      send_line(0, frame_a(8'h22), 10);
      din_a = 1'b1;
      repeat (40) tick();
      chk("ovr_valid", 32'(valid_a), 32'd1);
      chk("ovr_data", 32'(data_rx_a), 32'h11);
      chk("ovr_pulses", 32'(ov_a - ov0), 32'd1);
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
      chk("ovr_valid_drop", 32'(valid_a), 32'd0);
      chk("ovr_data_hold", 32'(data_rx_a), 32'h11);
      expect_word(0, "ovr_w", 8'h11, 1'b0, 1'b0);
      chk("ovr_extra", 32'(qa.size()), 32'd0);

      // Reset in the middle of DATA aborts the frame.
      ready_a = 1'b1;
      send_line(0, frame_a(8'h81), 4);
      chk("rstmid_busy_before", 32'(busy_a), 32'd1);
      rst = 1'b0;
      #1;
      chk("rstmid_busy", 32'(busy_a), 32'd0);
      chk("rstmid_data", 32'(data_rx_a), 32'd0);
      chk("rstmid_valid", 32'(valid_a), 32'd0);
      din_a = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      repeat (3) tick();
      send_line(0, frame_a(8'h81), 10);
      din_a = 1'b1;
      repeat (40) tick();
      expect_word(0, "rstmid_w", 8'h81, 1'b0, 1'b0);
      chk("rstmid_extra", 32'(qa.size()), 32'd0);

      // Even parity: correct, then wrong parity bit.
      send_line(1, frame_b(8'h07, 1'b1, 1'b1), 12);
      send_line(1, frame_b(8'h07, 1'b0, 1'b1), 12);
      din_b = 1'b1;
      repeat (40) tick();
      expect_word(1, "par_ok", 8'h07, 1'b0, 1'b0);
      expect_word(1, "par_bad", 8'h07, 1'b1, 1'b0);

      // Second stop bit low gives a framing error.
      send_line(1, frame_b(8'h55, 1'b0, 1'b0), 12);
      din_b = 1'b1;
      repeat (CPB) tick();
      expect_word(1, "stop2", 8'h55, 1'b0, 1'b1);

      // Break: one zero word with frame_err, then no retrigger while low.
      din_b = 1'b0;
      repeat (12 * CPB) tick();
      chk("brk_busy", 32'(busy_b), 32'd0);
      chk("brk_count", 32'(qb.size()), 32'd1);
      expect_word(1, "brk", 8'h00, 1'b0, 1'b1);
      din_b = 1'b1;
      repeat (2 * CPB) tick();
      chk("brk_nomore", 32'(qb.size()), 32'd0);
      send_line(1, frame_b(8'h07, 1'b1, 1'b1), 12);
      din_b = 1'b1;
      repeat (40) tick();
      expect_word(1, "brk_recover", 8'h07, 1'b0, 1'b0);
      chk("b_overrun", 32'(ov_b), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receive engine. It is the next generation of the fixed 8N1 receiver: data width, bit period, parity mode and stop-bit count are configurable. It adds an input synchroniser, parity and framing error reporting, and a valid/ready output holding register with overrun detection. It sits between the board RX pin and the command/FIFO logic.

Parameters:
CLKS_PER_BIT, 279, clock cycles per UART bit (minimum 4)
DATA_BITS, 8, payload bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
din  in  1  serial RX line, asynchronous, idle high
ready  in  1  consumer accepts the held word when valid && ready
data_rx  out  DATA_BITS  received payload, held while valid
valid  out  1  held word available
parity_err  out  1  parity mismatch for the held word (0 if PARITY == 0)
frame_err  out  1  at least one stop sample was low for the held word
overrun  out  1  one-cycle pulse: frame completed while valid was high; that frame is discarded
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, counter = 0, bit index = 0, shift register = 0; sync flops = 1; data_rx = 0; valid, parity_err, frame_err, overrun = 0. Deassertion takes effect on the next clk.
- din passes through a 2-flop synchroniser (din_s), reset value 1. All decisions use din_s.
- HALF = CLKS_PER_BIT/2 (integer division). The counter width is clog2(CLKS_PER_BIT).
- IDLE: counter = 0. When din_s == 0, go to START.
- START: counter increments. At counter == HALF-1:
  - if din_s == 1 (glitch), go to IDLE;
  - otherwise counter = 0 and go to DATA.
  - From here on, every sample falls at mid-bit.
- DATA: when counter == CLKS_PER_BIT-1, shift din_s in LSB-first, set counter = 0, increment index. After DATA_BITS samples, go to PARITY (PARITY != 0) or STOP. Otherwise counter increments.
- PARITY: one sample at counter == CLKS_PER_BIT-1.
  - Even: error if XOR(payload, sample) == 1.
  - Odd: error if XOR(payload, sample) == 0.
  - Then go to STOP.
- STOP: STOP_BITS samples at counter == CLKS_PER_BIT-1. Any low sample sets the frame-error flag. The frame completes on the last stop sample (mid-bit), and the state returns to IDLE the next cycle. A low line then restarts START immediately, which allows back-to-back frames.
- Commit on the completion cycle:
  - If valid == 0: on the next edge data_rx = payload, parity_err and frame_err are set per the frame, and valid = 1.
  - If valid == 1 and ready == 0: the output is unchanged, overrun pulses for 1 cycle, and the frame is discarded.
  - If valid == 1 and ready == 1 in the same cycle: the new frame replaces the old one, valid stays 1, and there is no overrun.
- Handshake: when valid && ready and no commit occurs, valid = 0 on the next edge. parity_err and frame_err clear with it. data_rx holds its last value.
- Error frames are still delivered (valid = 1 with the flags set). The consumer decides what to do with them.
- A break (line low through the stop bits) is delivered as payload 0 with frame_err = 1. The receiver then waits in IDLE until din_s goes high and falls again; the line being low on IDLE entry does not retrigger START until a fresh high-to-low transition.
- Reset mid-frame aborts the frame immediately. The output is cleared and no valid is produced.
- Latency: valid rises 1 cycle after the mid-point of the last stop bit, plus 2 cycles of synchroniser delay relative to din.

Test Plan:
- 8N1, CLKS_PER_BIT=16, ready=1: send 0xA5, then 0x3C back-to-back. Required: two valid pulses with data_rx = 0xA5 then 0x3C, parity_err = frame_err = 0, overrun never asserted.
- Glitch: din low for 5 cycles (< HALF = 8), then high. Required: returns to IDLE, busy low after the glitch, valid never asserted.
- PARITY=1 (even): send 0x07 with parity bit 1 (correct), then 0x07 with parity bit 0. Required: first word parity_err = 0, second word parity_err = 1, both with valid = 1.
- STOP_BITS=2: send 0x55 with the second stop bit low. Required: valid = 1, data_rx = 0x55, frame_err = 1. Then hold din low for 12 bit times. Required: one word 0x00 with frame_err = 1 and no further frames until din rises and falls again.
- ready=0: send 0x11, then 0x22. Required: data_rx stays 0x11, valid stays 1, overrun pulses exactly 1 cycle at completion of 0x22. Then ready=1 for 1 cycle. Required: valid drops next cycle.
- Reset: assert rst low mid-DATA of 0x81, release, then send 0x81 fully. Required: outputs are 0 asynchronously during reset, no valid from the aborted frame, and a correct 0x81 from the second frame.
